// File: rtl/dequeue_scheduler.sv
// Dequeue scheduler: round-robin grant across per-port PIFO heads, then
// streams the granted packet chunk by chunk from the packet buffer.
module dequeue_scheduler #(
    parameter int DATA_WIDTH        = 256,
    parameter int KEEP_WIDTH        = 32,
    parameter int OUTPUT_PORT_COUNT = 5,
    parameter int ADDR_WIDTH        = 11
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic [OUTPUT_PORT_COUNT-1:0]              s_axis_pifo_valid_bit_array,
    input  logic [OUTPUT_PORT_COUNT*ADDR_WIDTH-1:0]   s_axis_pifo_addr,
    output logic [OUTPUT_PORT_COUNT-1:0]              m_axis_ctl_pifo_deq,
    output logic                                      m_axis_buf_rd_en,
    output logic [2:0]                                m_axis_buf_rd_port,
    output logic [ADDR_WIDTH-1:0]                     m_axis_buf_rd_addr,
    input  logic [DATA_WIDTH+KEEP_WIDTH:0]            s_axis_buf_rd_data,
    output logic [DATA_WIDTH-1:0]                     m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]                     m_axis_tkeep,
    output logic                                      m_axis_tlast,
    output logic [OUTPUT_PORT_COUNT-1:0]              m_axis_tuser,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready
);

    localparam int N  = OUTPUT_PORT_COUNT;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_SEND = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [IW-1:0]         grant_q, grant_d;
    logic [IW-1:0]         last_q, last_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic                  first_q, first_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
    logic                  tlast_q, tlast_d;

    logic [ADDR_WIDTH-1:0] head_addr [N];
    logic                  rr_hit;
    logic [IW-1:0]         rr_idx;
    logic [IW-1:0]         cand;
    logic [N-1:0]          grant_oh;
    int                    j;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            head_addr[i] = s_axis_pifo_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Search starts one past the last grant so every port gets a turn.
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        cand   = '0;
        j      = 0;
        for (int k = 1; k <= N; k++) begin
            j    = (int'(last_q) + k) % N;
            cand = IW'(j);
            if (!rr_hit && s_axis_pifo_valid_bit_array[cand]) begin
                rr_hit = 1'b1;
                rr_idx = cand;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            grant_oh[i] = (grant_q == IW'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        cur_addr_d = cur_addr_q;
        first_d    = first_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tlast_d    = tlast_q;
        unique case (state_q)
            S_IDLE: begin
                if (rr_hit) begin
                    grant_d    = rr_idx;
                    last_d     = rr_idx;
                    cur_addr_d = head_addr[rr_idx];
                    first_d    = 1'b1;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                first_d = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                {tdata_d, tkeep_d, tlast_d} = s_axis_buf_rd_data;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (m_axis_tready) begin
                    if (tlast_q) begin
                        state_d = S_IDLE;
                    end else begin
                        cur_addr_d = cur_addr_q + 1'b1;
                        state_d    = S_READ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            last_q     <= IW'(N - 1);
            cur_addr_q <= '0;
            first_q    <= 1'b0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            cur_addr_q <= cur_addr_d;
            first_q    <= first_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tlast_q    <= tlast_d;
        end
    end

    // Outputs decode from registered state, so reset clears them at once.
    always_comb begin
        m_axis_buf_rd_en    = (state_q == S_READ);
        m_axis_ctl_pifo_deq = (m_axis_buf_rd_en && first_q) ? grant_oh : '0;
        m_axis_buf_rd_port  = m_axis_buf_rd_en ? 3'(grant_q) : 3'd0;
        m_axis_buf_rd_addr  = m_axis_buf_rd_en ? cur_addr_q : '0;
        m_axis_tuser        = (state_q != S_IDLE) ? grant_oh : '0;
        m_axis_tvalid       = (state_q == S_SEND);
        m_axis_tdata        = tdata_q;
        m_axis_tkeep        = tkeep_q;
        m_axis_tlast        = tlast_q;
    end

endmodule

// File: tb/tb_dequeue_scheduler.sv
// Bench for dequeue_scheduler: packet table driven through a scoreboard,
// plus backpressure, address wrap and mid-packet reset sequences.
module tb_dequeue_scheduler;

    localparam int DW = 256;
    localparam int KW = 32;
    localparam int N  = 5;
    localparam int AW = 11;

    logic            clk = 1'b0;
    logic            rstn = 1'b1;
    logic [N-1:0]    valid = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N-1:0]    deq;
    logic            rd_en;
    logic [2:0]      rd_port;
    logic [AW-1:0]   rd_addr;
    logic [DW+KW:0]  rd_data = '0;
    logic [DW-1:0]   tdata;
    logic [KW-1:0]   tkeep;
    logic            tlast;
    logic [N-1:0]    tuser;
    logic            tvalid;
    logic            tready = 1'b1;

    always #5 clk = ~clk;

    dequeue_scheduler #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
        .OUTPUT_PORT_COUNT(N), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .s_axis_pifo_valid_bit_array(valid),
        .s_axis_pifo_addr(addr),
        .m_axis_ctl_pifo_deq(deq),
        .m_axis_buf_rd_en(rd_en),
        .m_axis_buf_rd_port(rd_port),
        .m_axis_buf_rd_addr(rd_addr),
        .s_axis_buf_rd_data(rd_data),
        .m_axis_tdata(tdata),
        .m_axis_tkeep(tkeep),
        .m_axis_tlast(tlast),
        .m_axis_tuser(tuser),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready)
    );

    typedef struct {
        logic [N-1:0]  valid;
        logic [AW-1:0] addr;
        int            n;
        int            port;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic [N-1:0]  u;
    } beat_t;

    logic [N-1:0]  gq [$];
    logic [2+AW:0] rq [$];
    beat_t         bq [$];
    int            errors = 0;
    int            checks = 0;
    logic [AW-1:0] end_addr = '0;

    function automatic logic [DW+KW:0] mk(input logic [2:0] p,
                                          input logic [AW-1:0] a,
                                          input logic [AW-1:0] e);
        logic [31:0] w;
        w = {13'h0, p, 5'h0, a};
        return {{8{w}}, {21'h0, a}, (a == e)};
    endfunction

    always @(posedge clk) begin
        if (rd_en) rd_data <= mk(rd_port, rd_addr, end_addr);
    end

    task automatic chk(input string nm, input logic [319:0] act,
                       input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (rstn) begin
            if (deq != '0) begin
                if (gq.size() == 0) chk("deq_unexpected", deq, 0);
                else chk("deq", deq, gq.pop_front());
            end
            if (rd_en) begin
                if (rq.size() == 0) chk("rd_unexpected", rd_en, 0);
                else chk("rd_port_addr", {rd_port, rd_addr}, rq.pop_front());
            end
            if (tvalid && tready) begin
                if (bq.size() == 0) chk("beat_unexpected", tvalid, 0);
                else chk("beat", {tdata, tkeep, tlast, tuser}, bq.pop_front());
            end
        end
    end

    task automatic load(input vec_t v, output logic [DW-1:0] d0);
        logic [AW-1:0]  a;
        logic [DW+KW:0] m;
        logic [N-1:0]   oh;
        beat_t          b;
        d0    = '0;
        oh    = N'(1) << v.port;
        valid = v.valid;
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW] = (i == v.port) ? v.addr
                             : (v.addr ^ 11'h400 ^ AW'(i << 4));
        end
        end_addr = v.addr + AW'(v.n - 1);
        gq.push_back(oh);
        for (int k = 0; k < v.n; k++) begin
            a = v.addr + AW'(k);
            rq.push_back({3'(v.port), a});
            m   = mk(3'(v.port), a, end_addr);
            b.d = m[DW+KW:KW+1];
            b.k = m[KW:1];
            b.l = (k == v.n - 1);
            b.u = oh;
            bq.push_back(b);
            if (k == 0) d0 = b.d;
        end
    endtask

    task automatic wait_deq(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (deq != '0);
        end
        chk("grant_timeout", seen, 1);
    endtask

    task automatic run_pkt(input vec_t v, input int stall);
        logic [DW-1:0] d0;
        bit            seen;
        load(v, d0);
        tready = (stall == 0);
        wait_deq(seen);
        if (seen) begin
            @(negedge clk);
            chk("tvalid_wait", tvalid, 0);
            @(negedge clk);
            chk("tvalid_send", tvalid, 1);
            chk("tuser", tuser, N'(1) << v.port);
            for (int i = 0; i < stall; i++) begin
                chk("bp_tvalid", tvalid, 1);
                chk("bp_tdata", tdata, d0);
                chk("bp_rd_en", rd_en, 0);
                @(negedge clk);
            end
            tready = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                if (tvalid && tready && tlast) seen = 1'b1;
                else @(negedge clk);
            end
            chk("pkt_end_timeout", seen, 1);
            @(negedge clk);
            chk("idle_tvalid_tuser", {tvalid, tuser}, 0);
        end
        valid = '0;
    endtask

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d0;
        bit            seen;
        vec_t          v;

        tbl[0] = '{5'b11111, 11'h100, 1, 0};
        tbl[1] = '{5'b11111, 11'h120, 1, 1};
        tbl[2] = '{5'b11111, 11'h140, 1, 2};
        tbl[3] = '{5'b11111, 11'h160, 1, 3};
        tbl[4] = '{5'b11111, 11'h180, 1, 4};
        tbl[5] = '{5'b11111, 11'h1A0, 1, 0};
        tbl[6] = '{5'b00100, 11'h010, 2, 2};
        tbl[7] = '{5'b01010, 11'h7FF, 2, 3};
        tbl[8] = '{5'b01010, 11'h200, 3, 1};
        tbl[9] = '{5'b10000, 11'h300, 1, 4};

        #1 rstn = 1'b0;
        #2;
        chk("rst_deq", deq, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_port", rd_port, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tkeep", tkeep, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tuser", tuser, 0);
        chk("rst_tvalid", tvalid, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_valid", {deq, rd_en, tvalid}, 0);

        for (int r = 0; r < 10; r++) run_pkt(tbl[r], 0);

        run_pkt('{5'b00001, 11'h050, 2, 0}, 4);

        v = '{5'b00100, 11'h020, 3, 2};
        load(v, d0);
        tready = 1'b1;
        wait_deq(seen);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_mid_outs",
            {deq, rd_en, rd_port, rd_addr, tdata, tkeep, tlast, tuser, tvalid}, 0);
        gq.delete();
        rq.delete();
        bq.delete();
        valid = '0;
        repeat (2) @(negedge clk);
        chk("rst_hold_outs", {deq, rd_en, tvalid, tuser}, 0);
        rstn = 1'b1;
        run_pkt('{5'b10001, 11'h400, 1, 0}, 0);

        repeat (5) @(negedge clk);
        chk("queues_empty", gq.size() + rq.size() + bq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dequeue_scheduler.md
DEQUEUE_SCHEDULER -- requirements
Module: dequeue_scheduler

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- DATA_WIDTH, 256, packet chunk width
- KEEP_WIDTH, 32, byte-enable width
- OUTPUT_PORT_COUNT, 5, number of output ports and per-port PIFOs
- ADDR_WIDTH, 11, packet buffer chunk address width
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- s_axis_pifo_valid_bit_array  in  OUTPUT_PORT_COUNT  bit i = PIFO i has a head entry
- s_axis_pifo_addr  in  OUTPUT_PORT_COUNT*ADDR_WIDTH  head start address of PIFO i, slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_axis_ctl_pifo_deq  out  OUTPUT_PORT_COUNT  one-hot single-cycle pop of PIFO i
- m_axis_buf_rd_en  out  1  packet buffer read strobe
- m_axis_buf_rd_port  out  3  buffer bank (port index) to read
- m_axis_buf_rd_addr  out  ADDR_WIDTH  chunk address to read
- s_axis_buf_rd_data  in  DATA_WIDTH+KEEP_WIDTH+1  {data, keep, last}, valid exactly 1 cycle after rd_en
- m_axis_tdata  out  DATA_WIDTH  output chunk
- m_axis_tkeep  out  KEEP_WIDTH  output byte enables
- m_axis_tlast  out  1  last chunk of packet
- m_axis_tuser  out  OUTPUT_PORT_COUNT  one-hot destination port of current packet
- m_axis_tvalid  out  1  output chunk valid
- m_axis_tready  in  1  downstream accept

Function
REQ-003 FSM SHALL have states IDLE, READ, WAIT, SEND; state held in flip-flops.
REQ-004 IDLE: if s_axis_pifo_valid_bit_array != 0, SHALL grant one port by round-robin, latch grant index and its s_axis_pifo_addr slice into cur_addr, go to READ; else stay IDLE.
REQ-005 Round-robin SHALL search from (last_grant+1) upward, wrapping OUTPUT_PORT_COUNT-1 -> 0; last_grant updates only on a grant.
REQ-006 Ports with valid bit 0 in the IDLE cycle SHALL never be granted; valid-bit changes outside IDLE SHALL be ignored.
REQ-007 m_axis_ctl_pifo_deq SHALL be one-hot of the granted port for exactly one cycle: the first READ cycle of each packet; zero at all other times.
REQ-008 READ: m_axis_buf_rd_en=1, rd_port=grant index, rd_addr=cur_addr, for one cycle; next state WAIT. rd_en SHALL be 0 in all other states.
REQ-009 WAIT: SHALL capture s_axis_buf_rd_data into tdata/tkeep/tlast registers; next state SEND.
REQ-010 SEND: m_axis_tvalid=1; tdata/tkeep/tlast/tuser SHALL be stable while tvalid=1 and tready=0.
REQ-011 SEND with tready=1 and tlast=0: cur_addr <= cur_addr+1 modulo 2^ADDR_WIDTH (2^ADDR_WIDTH-1 wraps to 0); next READ.
REQ-012 SEND with tready=1 and tlast=1: next IDLE; tvalid deasserts next cycle.
REQ-013 Minimum per-chunk latency SHALL be 3 cycles (READ, WAIT, SEND); first deq-to-tvalid latency 2 cycles.
REQ-014 m_axis_tuser SHALL equal one-hot of grant index from grant until packet end; 0 in IDLE.
REQ-015 tvalid SHALL be 0 outside SEND; tready outside SEND SHALL have no effect.
REQ-016 A new grant SHALL NOT occur until the current packet's last chunk is accepted (no interleaving).

Reset
REQ-017 rstn=0 SHALL asynchronously force state=IDLE, cur_addr=0, last_grant=OUTPUT_PORT_COUNT-1 (port 0 first priority), grant index=0, and all outputs (deq, rd_en, rd_port, rd_addr, tdata, tkeep, tlast, tuser, tvalid) to 0.
REQ-018 Reset asserted mid-packet SHALL abandon the packet without further deq or rd_en; after release, scheduling restarts in IDLE with port 0 first.

Verification
REQ-019 Bench SHALL cover:
- Single packet: valid=5'b00100, addr[2]=0x010, 2 chunks, tready=1 -> deq=5'b00100 one cycle, reads 0x010 then 0x011 on port 2, two beats tuser=5'b00100, tlast on second.
- Round-robin: valid=5'b11111 held, 1-chunk packets -> grant order 0,1,2,3,4,0.
- Backpressure: tready=0 for 4 cycles in SEND -> tvalid held, tdata unchanged, no extra rd_en; beat accepted when tready=1.
- Address wrap: start addr 0x7FF, 2 chunks -> reads 0x7FF then 0x000.
- Reset mid-packet: rstn low in WAIT -> all outputs 0 immediately; after release valid=5'b10001 -> port 0 granted first.
